// File: rtl/reg_pkg.sv
// Shared definitions for the serializer: FSM state encoding and counter sizing.
package reg_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Counter width for a word of n bits; one bit is the floor so N=2 still works.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Loadable down-counter with a zero flag. Load has priority over decrement.
module bit_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage with valid/ready on both sides; a new word may be
// accepted on the same edge that consumes the last bit, so words stream gap-free.
module piso_serializer
  import reg_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  input  logic [N-1:0] load_data,
  output logic         load_ready,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_last,
  input  logic         ser_ready,
  output logic         busy
);

  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic         r_state;
  logic         w_state_nxt;
  logic [N-1:0] r_sh;
  logic         w_cnt_zero;
  logic         w_word_acc;
  logic         w_bit_acc;

  assign w_word_acc = load_valid & load_ready;
  assign w_bit_acc  = ser_valid & ser_ready;

  // Gated by rst so nothing is accepted while reset is held.
  assign load_ready = rst & ((r_state == ST_IDLE) | (ser_last & ser_ready));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_word_acc) w_state_nxt = ST_SHIFT;
      end
      default: begin
        if (w_bit_acc && w_cnt_zero) w_state_nxt = w_word_acc ? ST_SHIFT : ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ser_valid = (r_state == ST_SHIFT);
    busy      = (r_state == ST_SHIFT);
    ser_last  = (r_state == ST_SHIFT) & w_cnt_zero;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh <= '0;
    end else if (w_word_acc) begin
      r_sh <= load_data;
    end else if (w_bit_acc) begin
      if (MSB_FIRST) r_sh <= {r_sh[N-2:0], 1'b0};
      else           r_sh <= {1'b0, r_sh[N-1:1]};
    end
  end

  // Output bit is a register bit directly, no logic after the flop.
  assign ser_out = MSB_FIRST ? r_sh[N-1] : r_sh[0];

  bit_counter #(.W(CW)) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (w_word_acc),
    .load_val (CNT_LAST),
    .dec      (w_bit_acc),
    .zero     (w_cnt_zero)
  );

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (N=4): an MSB-first and an LSB-first instance.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       m_load_valid = 1'b0;
  logic [3:0] m_load_data  = '0;
  logic       m_load_ready;
  logic       m_ser_out, m_ser_valid, m_ser_last, m_busy;
  logic       m_ser_ready  = 1'b0;

  logic       l_load_valid = 1'b0;
  logic [3:0] l_load_data  = '0;
  logic       l_load_ready;
  logic       l_ser_out, l_ser_valid, l_ser_last, l_busy;
  logic       l_ser_ready  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.N(4), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst(rst),
    .load_valid(m_load_valid), .load_data(m_load_data), .load_ready(m_load_ready),
    .ser_out(m_ser_out), .ser_valid(m_ser_valid), .ser_last(m_ser_last),
    .ser_ready(m_ser_ready), .busy(m_busy)
  );

  piso_serializer #(.N(4), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst(rst),
    .load_valid(l_load_valid), .load_data(l_load_data), .load_ready(l_load_ready),
    .ser_out(l_ser_out), .ser_valid(l_ser_valid), .ser_last(l_ser_last),
    .ser_ready(l_ser_ready), .busy(l_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp4;
  logic [7:0] exp8;
  logic [3:0] got_bits;
  int         n_acc;

  initial begin
    // Reset state
    #2;
    check("rst_ser_out",    m_ser_out,    0);
    check("rst_ser_valid",  m_ser_valid,  0);
    check("rst_load_ready", m_load_ready, 0);
    check("rst_busy",       m_busy,       0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rel_load_ready", m_load_ready, 1);
    check("rel_ser_valid",  m_ser_valid,  0);
    next_cycle();

    // MSB first, 1010
    exp4 = 4'b1010;
    m_load_data = exp4; m_load_valid = 1'b1; m_ser_ready = 1'b1;
    next_cycle();
    m_load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("msb_out%0d", i),   m_ser_out,   exp4[3-i]);
      check($sformatf("msb_valid%0d", i), m_ser_valid, 1);
      check($sformatf("msb_last%0d", i),  m_ser_last,  (i == 3));
      check($sformatf("msb_busy%0d", i),  m_busy,      1);
      next_cycle();
    end
    @(negedge clk);
    check("msb_busy_end",  m_busy,      0);
    check("msb_valid_end", m_ser_valid, 0);
    next_cycle();

    // LSB first, 1010 -> 0,1,0,1
    l_load_data = 4'b1010; l_load_valid = 1'b1; l_ser_ready = 1'b1;
    next_cycle();
    l_load_valid = 1'b0;
    exp4 = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("lsb_out%0d", i),  l_ser_out,  exp4[3-i]);
      check($sformatf("lsb_last%0d", i), l_ser_last, (i == 3));
      next_cycle();
    end
    @(negedge clk);
    check("lsb_busy_end", l_busy, 0);
    next_cycle();

    // Backpressure: 1100, stall 3 cycles after first bit
    m_load_data = 4'b1100; m_load_valid = 1'b1; m_ser_ready = 1'b1;
    next_cycle();
    m_load_valid = 1'b0;
    n_acc = 0; got_bits = '0;
    for (int c = 0; c < 7; c++) begin
      m_ser_ready = !(c >= 1 && c <= 3);
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        check($sformatf("bp_hold_out%0d", c),   m_ser_out,   1);
        check($sformatf("bp_hold_valid%0d", c), m_ser_valid, 1);
        check($sformatf("bp_hold_last%0d", c),  m_ser_last,  0);
      end
      if (m_ser_valid && m_ser_ready) begin
        if (n_acc < 4) got_bits[3-n_acc] = m_ser_out;
        n_acc++;
      end
      next_cycle();
    end
    m_ser_ready = 1'b1;
    check("bp_accepts", n_acc, 4);
    check("bp_bits", got_bits, 4'b1100);
    @(negedge clk);
    check("bp_idle", m_busy, 0);
    next_cycle();

    // Back-to-back: 1100 then 0011 with load_valid held
    exp8 = 8'b1100_0011;
    m_load_data = 4'b1100; m_load_valid = 1'b1;
    next_cycle();
    m_load_data = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b_out%0d", i),   m_ser_out,    exp8[7-i]);
      check($sformatf("b2b_valid%0d", i), m_ser_valid,  1);
      check($sformatf("b2b_last%0d", i),  m_ser_last,   (i == 3 || i == 7));
      check($sformatf("b2b_lrdy%0d", i),  m_load_ready, (i == 3 || i == 7));
      next_cycle();
      if (i == 3) m_load_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle", m_ser_valid, 0);
    next_cycle();

    // Load ignored mid-word: 1111 offered from bit 2 of 1010
    exp4 = 4'b1010;
    m_load_data = exp4; m_load_valid = 1'b1;
    next_cycle();
    m_load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        m_load_data = 4'b1111; m_load_valid = 1'b1;
      end
      @(negedge clk);
      check($sformatf("ign_out%0d", i), m_ser_out, exp4[3-i]);
      if (i == 1) check("ign_lrdy_mid", m_load_ready, 0);
      if (i == 3) check("ign_lrdy_last", m_load_ready, 1);
      next_cycle();
    end
    m_load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("ign_new%0d", i),  m_ser_out,   1);
      check($sformatf("ign_nvld%0d", i), m_ser_valid, 1);
      next_cycle();
    end
    @(negedge clk);
    check("ign_idle", m_busy, 0);
    next_cycle();

    // Reset mid-shift: 1010, two bits sent, then asynchronous reset
    m_load_data = 4'b1010; m_load_valid = 1'b1;
    next_cycle();
    m_load_valid = 1'b0;
    next_cycle();
    next_cycle();
    #2;
    check("mid_pre_out", m_ser_out, 1);
    rst = 1'b0;
    #1;
    check("mid_ser_out",    m_ser_out,    0);
    check("mid_ser_valid",  m_ser_valid,  0);
    check("mid_ser_last",   m_ser_last,   0);
    check("mid_busy",       m_busy,       0);
    check("mid_load_ready", m_load_ready, 0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rel_lrdy",  m_load_ready, 1);
    check("mid_rel_valid", m_ser_valid,  0);
    next_cycle();
    @(negedge clk);
    check("mid_rel_valid2", m_ser_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
